// File: rtl/mem_access_unit.sv
// Memory access unit: MAR, MDR and on-chip data RAM, sequenced IDLE -> WAIT -> XFER -> ACK.
// Optional feature: define MEM_PARITY_EN to store and check an even-parity bit per RAM word.
module mem_access_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] busIn,
  input  logic              marIn,
  input  logic              mdrWriteEN,
  input  logic              mdrReadEN,
  input  logic              memEN,
  input  logic              RW,
  input  logic              mdrOut,
  output logic [DATA_W-1:0] busOut,
  output logic              memBusy,
  output logic              memAck,
  output logic              addrErr,
  output logic              busErr,
  output logic              parErr,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ACK} state_t;

`ifdef MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t              state, nxt;
  logic [3:0]          wait_cnt;
  logic                op_write, op_rden;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_data;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic                addr_err_q, bus_err_q;
  logic [RAM_W-1:0]    ram [0:DEPTH-1];

  logic                in_range, regs_open, accept, collide;
  logic [RAM_W-1:0]    rd_word, wr_word;
  logic [DATA_W-1:0]   rd_data;

  // The access works on the MAR/MDR values captured at acceptance, so a
  // same-edge register load never leaks busIn into the transfer.
  assign in_range  = ({1'b0, op_addr} < DEPTH_L);
  assign regs_open = (state == S_IDLE) || (state == S_ACK);
  assign accept    = (state == S_IDLE) && memEN;
  assign collide   = ((state == S_WAIT) || (state == S_XFER)) && (marIn || mdrWriteEN || memEN);
  assign rd_word   = in_range ? ram[op_addr] : '0;
  assign rd_data   = rd_word[DATA_W-1:0];

`ifdef MEM_PARITY_EN
  assign wr_word = {^op_data, op_data};
`else
  assign wr_word = op_data;
`endif

  assign busOut    = mdrOut ? mdr : '0;
  assign addrErr   = addr_err_q;
  assign busErr    = bus_err_q;
  assign state_dbg = state;

  always_comb begin
    nxt     = state;
    memBusy = 1'b0;
    memAck  = 1'b0;
    case (state)
      S_IDLE: if (memEN) nxt = (WAIT_CYC == 0) ? S_XFER : S_WAIT;
      S_WAIT: begin
        memBusy = 1'b1;
        if (wait_cnt == 4'd0) nxt = S_XFER;
      end
      S_XFER: begin
        memBusy = 1'b1;
        nxt     = S_ACK;
      end
      S_ACK: begin
        memAck = 1'b1;
        nxt    = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      op_write   <= 1'b0;
      op_rden    <= 1'b0;
      op_addr    <= '0;
      op_data    <= '0;
      mar        <= '0;
      mdr        <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        op_write <= RW;
        op_rden  <= mdrReadEN;
        op_addr  <= mar;
        op_data  <= mdr;
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (regs_open && marIn) mar <= busIn[ADDR_W-1:0];
      if ((state == S_XFER) && !op_write && op_rden)
        mdr <= in_range ? rd_data : '0;
      else if (regs_open && mdrWriteEN)
        mdr <= busIn;
      if ((state == S_XFER) && !in_range) addr_err_q <= 1'b1;
      if (collide) bus_err_q <= 1'b1;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else if ((state == S_XFER) && !op_write && in_range && (^rd_word)) par_err_q <= 1'b1;
  end
  assign parErr = par_err_q;
`else
  assign parErr = 1'b0;
`endif

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if ((state == S_XFER) && op_write && in_range) ram[op_addr] <= wr_word;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed load/store/error scenarios
// followed by randomized traffic against a transaction-level reference model.
module tb_mem_access_unit;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int W     = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] busIn = '0;
  logic marIn = 0, mdrWriteEN = 0, mdrReadEN = 0, memEN = 0, RW = 0, mdrOut = 0;
  logic [DW-1:0] busOut;
  logic memBusy, memAck, addrErr, busErr, parErr;
  logic [1:0] state_dbg;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst), .busIn(busIn), .marIn(marIn), .mdrWriteEN(mdrWriteEN),
    .mdrReadEN(mdrReadEN), .memEN(memEN), .RW(RW), .mdrOut(mdrOut),
    .busOut(busOut), .memBusy(memBusy), .memAck(memAck), .addrErr(addrErr),
    .busErr(busErr), .parErr(parErr), .state_dbg(state_dbg)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // reference model: an access is a timer of W+1 edges, then the transfer and an ack cycle
  logic [DW-1:0] m_ram [0:255];
  bit            m_bad [0:255];
  logic [DW-1:0] init_val [0:255];
  logic [AW-1:0] m_mar, a_addr;
  logic [DW-1:0] m_mdr, a_data;
  bit m_active, m_ack, m_aerr, m_berr, m_perr, a_write, a_rden;
  int m_t;

  initial for (int i = 0; i < 256; i++) m_bad[i] = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_t = 0; m_ack = 0; m_mar = '0; m_mdr = '0;
      m_aerr = 0; m_berr = 0; m_perr = 0;
    end else if (m_active) begin
      if (marIn || mdrWriteEN || memEN) m_berr = 1;
      m_t++;
      if (m_t == W + 1) begin
        if (int'(a_addr) >= DEPTH) begin
          m_aerr = 1;
          if (!a_write && a_rden) m_mdr = '0;
        end else if (a_write) begin
          m_ram[a_addr] = a_data;
          m_bad[a_addr] = 0;
        end else begin
          if (m_bad[a_addr]) m_perr = 1;
          if (a_rden) m_mdr = m_ram[a_addr];
        end
        m_active = 0;
        m_ack    = 1;
      end
    end else begin
      if (!m_ack && memEN) begin
        m_active = 1; m_t = 0;
        a_write = RW; a_rden = mdrReadEN; a_addr = m_mar; a_data = m_mdr;
      end
      m_ack = 0;
      if (marIn) m_mar = busIn[AW-1:0];
      if (mdrWriteEN) m_mdr = busIn;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(posedge clk) begin
    if (chk_on) begin
      #2;
      check("busy", memBusy, m_active);
      check("ack", memAck, m_ack);
      check("busOut", busOut, mdrOut ? m_mdr : '0);
      check("addrErr", addrErr, m_aerr);
      check("busErr", busErr, m_berr);
      check("parErr", parErr, m_perr);
    end
  end

  // driver tasks
  task automatic set_regs(input bit m, input bit d, input logic [DW-1:0] v);
    @(negedge clk); marIn = m; mdrWriteEN = d; busIn = v;
    @(negedge clk); marIn = 0; mdrWriteEN = 0;
  endtask

  task automatic access(input bit rw, input bit rden, input int hit, input string name);
    @(negedge clk); memEN = 1; RW = rw; mdrReadEN = rden;
    for (int i = 0; i <= W + 2; i++) begin
      @(posedge clk); #2;
      check({name, "_busy_t"}, memBusy, i <= W);
      check({name, "_ack_t"}, memAck, i == W + 1);
      if (i == 0) memEN = 0;
      if (i == hit) begin marIn = 1; busIn = 16'h000A; end
      if (i == hit + 1) marIn = 0;
    end
  endtask

  task automatic read_bus(input logic [DW-1:0] exp, input string name);
    @(negedge clk); mdrOut = 1;
    @(posedge clk); #2;
    check(name, busOut, exp);
    @(negedge clk); mdrOut = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0; chk_on = 1;
    @(posedge clk); #2;
    check("rst_busy", memBusy, 0);
    check("rst_ack", memAck, 0);
    check("rst_errs", {addrErr, busErr, parErr}, 3'b000);
    read_bus(16'h0000, "rst_mdr");

    // fill every legal word; MAR and MDR load together, so the low byte is the address
    for (int a = 0; a < DEPTH; a++) begin
      init_val[a] = {8'($urandom_range(0, 255)), 8'(a)};
      set_regs(1, 1, init_val[a]);
      access(1, 0, -1, "init");
    end

    // store then load
    set_regs(1, 0, 16'h0005);
    set_regs(0, 1, 16'hBEEF);
    access(1, 0, -1, "store");
    set_regs(0, 1, 16'h0000);
    read_bus(16'h0000, "mdr_cleared");
    access(0, 1, -1, "load");
    read_bus(16'hBEEF, "load_data");

    // dummy read leaves MDR alone
    set_regs(0, 1, 16'h1234);
    access(0, 0, -1, "dummy");
    read_bus(16'h1234, "dummy_mdr");

    // MAR load attempted during WAIT is dropped and flagged
    access(0, 1, 1, "coll");
    check("coll_busErr", busErr, 1);
    access(0, 1, -1, "coll_rd");
    read_bus(16'hBEEF, "coll_mar_kept");

    // out-of-range address
    set_regs(1, 0, 16'h00C8);
    set_regs(0, 1, 16'hFFFF);
    access(1, 0, -1, "oor_wr");
    check("oor_addrErr", addrErr, 1);
    access(0, 1, -1, "oor_rd");
    read_bus(16'h0000, "oor_mdr");
    set_regs(1, 0, 16'h0048);
    access(0, 1, -1, "alias_rd");
    read_bus(init_val[8'h48], "alias_kept");

    // reset during WAIT cancels the write
    set_regs(1, 0, 16'h0003);
    set_regs(0, 1, 16'hAAAA);
    @(negedge clk); memEN = 1; RW = 1;
    @(negedge clk); memEN = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("mid_rst_busy", memBusy, 0);
    check("mid_rst_errs", {addrErr, busErr, parErr}, 3'b000);
    check("mid_rst_bus", busOut, 16'h0000);
    repeat (4) begin
      @(posedge clk); #2;
      check("mid_rst_noack", memAck, 0);
    end
    set_regs(1, 0, 16'h0003);
    access(0, 1, -1, "mid_rst_rd");
    read_bus(init_val[3], "mid_rst_ram");

`ifdef MEM_PARITY_EN
    @(negedge clk);
    dut.ram[7][DW] = ~dut.ram[7][DW];
    m_bad[7] = 1;
    set_regs(1, 0, 16'h0007);
    access(0, 1, -1, "par_rd");
    check("par_err", parErr, 1);
    read_bus(init_val[7], "par_data");
`endif

    // randomized traffic
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [DW-1:0] v;
      @(negedge clk);
      v = DW'($urandom);
      if ($urandom_range(0, 7) != 0) v[AW-1:0] = AW'($urandom_range(0, DEPTH - 1));
      busIn      = v;
      marIn      = ($urandom_range(0, 9) < 3);
      mdrWriteEN = ($urandom_range(0, 9) < 3);
      memEN      = ($urandom_range(0, 9) < 3);
      RW         = 1'($urandom_range(0, 1));
      mdrReadEN  = ($urandom_range(0, 3) != 0);
      mdrOut     = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    marIn = 0; mdrWriteEN = 0; memEN = 0; mdrOut = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access unit sitting directly downstream of the memory-sequencing FSM in the microcontroller datapath. Owns the MAR, the MDR and the on-chip data RAM, and executes the load/store transfers commanded by the FSM's control strobes (marIn, mdrWriteEN, mdrReadEN, mdrOut, memEN, RW). It drives read data back onto the internal 16-bit bus and reports completion with a one-cycle acknowledge, so the sequencing FSM can advance.

## Interface
- DATA_W, 16, data bus / MDR / word width
- ADDR_W, 8, MAR width; MAR loads busIn[ADDR_W-1:0]
- DEPTH, 256, RAM words; legal addresses 0..DEPTH-1 (DEPTH ≤ 2^ADDR_W)
- WAIT_CYC, 2, wait-state cycles before the transfer (0..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- busIn  in  DATA_W  internal bus into MAR/MDR
- marIn  in  1  latch busIn[ADDR_W-1:0] into MAR
- mdrWriteEN  in  1  latch busIn into MDR
- mdrReadEN  in  1  on an accepted read, capture RAM data into MDR
- memEN  in  1  start access (sampled only in IDLE)
- RW  in  1  0 = read RAM→MDR, 1 = write MDR→RAM; sampled with memEN
- mdrOut  in  1  drive MDR onto busOut
- busOut  out  DATA_W  MDR when mdrOut=1, else 0 (combinational)
- memBusy  out  1  high in WAIT and XFER
- memAck  out  1  one-cycle completion pulse (ACK state)
- addrErr  out  1  sticky: access attempted with MAR ≥ DEPTH
- busErr  out  1  sticky: marIn/mdrWriteEN/memEN asserted while busy
- parErr  out  1  sticky parity error (see Configuration)

## Operation
- States: IDLE, WAIT, XFER, ACK.
- IDLE: memEN=1 → latch RW and mdrReadEN into op registers; go WAIT (WAIT_CYC>0) or XFER (WAIT_CYC=0); load wait counter with WAIT_CYC-1.
- WAIT: counter decrements each cycle; at 0 → XFER.
- XFER: write: RAM[MAR] ← MDR. Read: MDR ← RAM[MAR] if latched mdrReadEN=1, else MDR unchanged (dummy read). → ACK.
- ACK: memAck=1, memBusy=0; → IDLE unconditionally. memEN in ACK ignored.
- MAR/MDR loads in IDLE/ACK: take effect at the edge; marIn and mdrWriteEN together both load from busIn.
- memEN in same cycle as marIn/mdrWriteEN: access uses pre-edge MAR/MDR contents (register values, not busIn).
- In WAIT/XFER: marIn, mdrWriteEN, memEN ignored (registers unchanged, no queueing), busErr set.
- MAR ≥ DEPTH at XFER: write suppressed; read loads 0 into MDR (if mdrReadEN latched); addrErr set; ACK still issued.
- busOut never reflects RAM directly; only MDR.

## Timing
- Reset: state IDLE, MAR=0, MDR=0, counter=0, memBusy=0, memAck=0, addrErr=busErr=parErr=0, busOut=0 (mdrOut=0). RAM contents not reset.
- memEN sampled at edge k: memBusy high from k to k+WAIT_CYC+1; XFER committed at edge k+WAIT_CYC+1; memAck high for the cycle after that edge; MDR read data valid in that same cycle.
- WAIT_CYC=2: ack after edge k+3. WAIT_CYC=0: ack after edge k+1.
- Back-to-back: next memEN accepted earliest one cycle after ack (in IDLE); throughput WAIT_CYC+3 cycles/access.
- rst mid-access: immediate return to IDLE, no RAM write if XFER edge not reached, memAck never issued.

## Configuration
- MEM_PARITY_EN defined: RAM stores DATA_W+1 bits; write stores even parity of MDR; read (valid address) checks parity, mismatch sets parErr sticky, data still loaded.
- Undefined: RAM DATA_W bits, no check, parErr tied 0.

## Test plan
- Store/load: MAR←0x05, MDR←0xBEEF, memEN RW=1; clear MDR; memEN RW=0 mdrReadEN=1 → MDR=0xBEEF, busOut=0xBEEF with mdrOut, memAck one cycle after edge k+3.
- Dummy read: MDR=0x1234, read RAM[5]=0xBEEF with mdrReadEN=0 → ack issued, MDR stays 0x1234.
- Busy collision: memEN, then marIn busIn=0x0A during WAIT → MAR unchanged, busErr=1, ack timing unaffected.
- Out-of-range: DEPTH=200, MAR=0xC8 write 0xFFFF then read → addrErr=1, MDR=0, RAM[0x48] unchanged.
- Reset mid-access: write 0xAAAA to MAR 3, rst in WAIT → IDLE, no memAck, RAM[3] keeps old value, outputs at reset values.
- MEM_PARITY_EN: force-flip stored parity bit of RAM[7], read → parErr=1, MDR holds data word.
